cu_sleep_monitor: RTL
=====================

CU_SLEEP_MONITOR -- requirements
Module: cu_sleep_monitor

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp-active inputs.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, max in-flight memory requests tracked.
REQ-003 SHALL have parameter IDLE_CYCLES, default 8, consecutive quiet cycles required before sleep; legal range 1..255.
REQ-004 SHALL have port clk_i, input, 1, single clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port kernel_start_i, input, 1, one-cycle pulse to start or wake the CU.
REQ-007 SHALL have port warp_active_i, input, NUM_WARPS, per-warp active flags from the CU scheduler.
REQ-008 SHALL have ports mem_req_valid_i and mem_req_ready_i, inputs, 1 each, CU memory request handshake (observed only).
REQ-009 SHALL have port mem_rsp_valid_i, input, 1, one memory response per asserted cycle.
REQ-010 SHALL have port sleep_req_o, output, 1, drives cu_sleep_req_i of the GPU power controller.
REQ-011 SHALL have port delay_sleep_o, output, 1, drives cu_delay_sleep_i of the GPU power controller.
REQ-012 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1), current in-flight count.
REQ-013 SHALL have port err_o, output, 1, sticky protocol-error flag.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, HOLD, SLEEP.
REQ-015 IDLE/SLEEP + kernel_start_i -> RUN next cycle; kernel_start_i in RUN/DRAIN/HOLD ignored.
REQ-016 On RUN entry, clear seen_active flag; set it on any cycle in RUN with warp_active_i != 0.
REQ-017 RUN -> DRAIN when seen_active=1 and warp_active_i == 0.
REQ-018 DRAIN -> HOLD when outstanding == 0 and no request handshake this cycle; on HOLD entry idle_cnt = 0.
REQ-019 HOLD: any warp_active_i bit or mem_req_valid_i -> RUN (seen_active set immediately); otherwise idle_cnt increments.
REQ-020 HOLD -> SLEEP on the cycle idle_cnt == IDLE_CYCLES-1 with no activity; IDLE_CYCLES=1 means one HOLD cycle.
REQ-021 sleep_req_o SHALL be registered, 1 exactly while in SLEEP.
REQ-022 delay_sleep_o SHALL be registered, 1 while state is DRAIN or HOLD, or outstanding != 0.
REQ-023 Outstanding counter: +1 on mem_req_valid_i & mem_req_ready_i, -1 on mem_rsp_valid_i, unchanged when both occur.
REQ-024 Increment at MAX_OUTSTANDING SHALL saturate and set err_o; decrement at 0 SHALL hold 0 and set err_o.
REQ-025 Request handshake or warp activity while in SLEEP SHALL set err_o; state stays SLEEP.
REQ-026 err_o SHALL clear only by reset.
REQ-027 All outputs SHALL be registered; FSM update latency one cycle from the qualifying input.

Reset
REQ-028 rst_ni low SHALL asynchronously force state IDLE, outstanding 0, idle_cnt 0, seen_active 0.
REQ-029 During reset sleep_req_o=0, delay_sleep_o=0, outstanding_o=0, err_o=0.
REQ-030 Reset mid-DRAIN with requests in flight SHALL discard count without setting err_o.

Verification
REQ-031 Start pulse, warps 0001 for 5 cycles then 0000, no memory traffic -> DRAIN 1 cycle, HOLD 8 cycles, sleep_req_o=1 on cycle 10 after warps drop.
REQ-032 3 request handshakes in RUN, warps drop, responses 20 cycles later -> DRAIN held, delay_sleep_o=1 throughout, outstanding_o 3->0, then SLEEP after 8 HOLD cycles.
REQ-033 In HOLD at idle_cnt=5, warp_active_i=0010 -> RUN next cycle, sleep_req_o stays 0, delay_sleep_o falls unless outstanding != 0.
REQ-034 Same-cycle request handshake and response at outstanding=2 -> outstanding_o stays 2, err_o 0.
REQ-035 17 handshakes with no responses -> outstanding_o=16, err_o=1; then mem_rsp_valid_i with outstanding 0 -> err_o stays 1.
REQ-036 In SLEEP, kernel_start_i pulse -> RUN next cycle, sleep_req_o=0; rst_ni low mid-DRAIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/cu_sleep_monitor.sv
// cu_sleep_monitor: watches a compute unit's warp activity and memory traffic
// and tells the GPU power controller when the CU may be put to sleep.
//
// Ports:
//   clk_i            single clock
//   rst_ni           asynchronous active-low reset
//   kernel_start_i   one-cycle pulse that starts or wakes the CU
//   warp_active_i    per-warp active flags from the CU scheduler
//   mem_req_valid_i  memory request valid (observed only)
//   mem_req_ready_i  memory request ready (observed only)
//   mem_rsp_valid_i  one memory response per asserted cycle
//   sleep_req_o      to cu_sleep_req_i of the power controller, high while in SLEEP
//   delay_sleep_o    to cu_delay_sleep_i, high while draining/holding or requests in flight
//   outstanding_o    current number of in-flight memory requests
//   err_o            sticky protocol-error flag, cleared only by reset
module cu_sleep_monitor #(
    parameter int unsigned NUM_WARPS       = 4,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned IDLE_CYCLES     = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   kernel_start_i,
    input  logic [NUM_WARPS-1:0]                   warp_active_i,
    input  logic                                   mem_req_valid_i,
    input  logic                                   mem_req_ready_i,
    input  logic                                   mem_rsp_valid_i,
    output logic                                   sleep_req_o,
    output logic                                   delay_sleep_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IDLE_W = 8;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_SLEEP = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                seen_active_q, seen_active_d;
    logic                sleep_req_q, sleep_req_d;
    logic                delay_sleep_q, delay_sleep_d;
    logic                err_q, err_d;

    logic                req_hs;
    logic                any_warp;
    logic                cnt_ovf;
    logic                cnt_unf;
    logic                sleep_viol;

    assign req_hs   = mem_req_valid_i & mem_req_ready_i;
    assign any_warp = |warp_active_i;

    // In-flight request counter; simultaneous request and response cancel out.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_ovf = 1'b0;
        cnt_unf = 1'b0;
        if (req_hs && !mem_rsp_valid_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_ovf = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!req_hs && mem_rsp_valid_i) begin
            if (cnt_q == '0) begin
                cnt_unf = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Next-state logic and registered-output precompute.
    always_comb begin
        state_d       = state_q;
        seen_active_d = seen_active_q;
        idle_cnt_d    = idle_cnt_q;
        sleep_viol    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (kernel_start_i) begin
                    state_d       = S_RUN;
                    seen_active_d = 1'b0;
                end
            end
            S_RUN: begin
                // Only leave RUN once warps have actually run and then gone quiet.
                if (seen_active_q && !any_warp) begin
                    state_d = S_DRAIN;
                end else if (any_warp) begin
                    seen_active_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if ((cnt_q == '0) && !req_hs) begin
                    state_d    = S_HOLD;
                    idle_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (any_warp || mem_req_valid_i) begin
                    state_d       = S_RUN;
                    seen_active_d = 1'b1;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = S_SLEEP;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            S_SLEEP: begin
                sleep_viol = req_hs || any_warp;
                if (kernel_start_i) begin
                    state_d       = S_RUN;
                    seen_active_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sleep_req_d   = (state_d == S_SLEEP);
        delay_sleep_d = (state_d == S_DRAIN) || (state_d == S_HOLD) || (cnt_d != '0);
        err_d         = err_q | cnt_ovf | cnt_unf | sleep_viol;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idle_cnt_q    <= '0;
            seen_active_q <= 1'b0;
            sleep_req_q   <= 1'b0;
            delay_sleep_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            seen_active_q <= seen_active_d;
            sleep_req_q   <= sleep_req_d;
            delay_sleep_q <= delay_sleep_d;
            err_q         <= err_d;
        end
    end

    assign sleep_req_o   = sleep_req_q;
    assign delay_sleep_o = delay_sleep_q;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule
